// File: rtl/bist_pkg.sv
// Shared definitions for the BIST datapath.
// Fault-site codes and the circuit-under-test response type.
package bist_pkg;

    localparam logic [1:0] FS_SUM  = 2'd0;
    localparam logic [1:0] FS_COUT = 2'd1;
    localparam logic [1:0] FS_P    = 2'd2;
    localparam logic [1:0] FS_G    = 2'd3;

    typedef logic [1:0] cut_resp_t;

    // Pack carry and sum into a response word, carry in bit 1.
    function automatic cut_resp_t packResp(input logic cout, input logic sum);
        return {cout, sum};
    endfunction

endpackage

// File: rtl/half_adder.sv
// Half adder building block.
// Produces sum s = x^y and carry c = x&y.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    // Purely combinational sum and carry.
    always_comb begin
        s = x ^ y;
        c = x & y;
    end

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder used as the BIST circuit-under-test.
// Optional stuck-at injection on sum, cout and the internal p/g nodes.
module full_adder
    import bist_pkg::*;
#(
    parameter int unsigned FAULT_INJ = 1
) (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic [1:0] dataIn,
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fault_en,
    input  logic [1:0] fault_site,
    input  logic       fault_val,
    output logic [1:0] dataIn_q
);

    logic injEn;
    logic p;
    logic g;
    logic pEff;
    logic gEff;
    logic sRaw;
    logic pc;
    logic sumOut;
    logic coutOut;

    // Injection collapses to constant 0 when the build omits it.
    assign injEn = (FAULT_INJ != 0) && fault_en;

    half_adder uHaPg (
        .x (a),
        .y (b),
        .s (p),
        .c (g)
    );

    // Internal node overrides for the propagate/generate faults.
    always_comb begin
        pEff = p;
        gEff = g;
        if (injEn && (fault_site == FS_P)) begin
            pEff = fault_val;
        end
        if (injEn && (fault_site == FS_G)) begin
            gEff = fault_val;
        end
    end

    half_adder uHaSum (
        .x (pEff),
        .y (cin),
        .s (sRaw),
        .c (pc)
    );

    // Carry merge and output-node overrides.
    always_comb begin
        sumOut  = sRaw;
        coutOut = gEff | pc;
        if (injEn && (fault_site == FS_SUM)) begin
            sumOut = fault_val;
        end
        if (injEn && (fault_site == FS_COUT)) begin
            coutOut = fault_val;
        end
    end

    assign dataIn = packResp(coutOut, sumOut);

    // Registered response copy for clocked compaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataIn_q <= 2'b00;
        end else begin
            dataIn_q <= dataIn;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder.
// Two builds: injection present and injection removed.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       cin = 1'b0;
    logic       fault_en = 1'b0;
    logic [1:0] fault_site = 2'd0;
    logic       fault_val = 1'b0;
    logic [1:0] dataIn;
    logic [1:0] dataIn_q;
    logic [1:0] dataIn0;
    logic [1:0] dataIn_q0;

    int nChecks = 0;
    int nFails = 0;
    bit started = 1'b0;

    logic [1:0] expQ;
    logic [1:0] expQ0;

    always #5 clk = ~clk;

    full_adder #(.FAULT_INJ(1)) dut (
        .a          (a),
        .b          (b),
        .cin        (cin),
        .dataIn     (dataIn),
        .clk        (clk),
        .rst_n      (rst_n),
        .fault_en   (fault_en),
        .fault_site (fault_site),
        .fault_val  (fault_val),
        .dataIn_q   (dataIn_q)
    );

    full_adder #(.FAULT_INJ(0)) dut0 (
        .a          (a),
        .b          (b),
        .cin        (cin),
        .dataIn     (dataIn0),
        .clk        (clk),
        .rst_n      (rst_n),
        .fault_en   (fault_en),
        .fault_site (fault_site),
        .fault_val  (fault_val),
        .dataIn_q   (dataIn_q0)
    );

    // Arithmetic model: plain sum when fault-free, node rules otherwise.
    function automatic logic [1:0] model(input logic ia, input logic ib,
                                         input logic ic, input logic en,
                                         input logic [1:0] site,
                                         input logic v);
        int ab;
        int pn;
        int gn;
        int s;
        int co;
        ab = int'(ia) + int'(ib);
        if (!en) return 2'(ab + int'(ic));
        pn = ab % 2;
        gn = ab / 2;
        if (site == 2'd2) pn = int'(v);
        if (site == 2'd3) gn = int'(v);
        s = (pn + int'(ic)) % 2;
        co = (gn != 0 || (pn != 0 && ic)) ? 1 : 0;
        if (site == 2'd0) s = int'(v);
        if (site == 2'd1) co = int'(v);
        return {co[0], s[0]};
    endfunction

    task automatic check(input string name, input logic [1:0] act,
                         input logic [1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Expected register contents for both builds.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ  <= 2'b00;
            expQ0 <= 2'b00;
        end else begin
            expQ  <= model(a, b, cin, fault_en, fault_site, fault_val);
            expQ0 <= model(a, b, cin, 1'b0, fault_site, fault_val);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("cmp_dataIn", dataIn,
                  model(a, b, cin, fault_en, fault_site, fault_val));
            check("cmp_dataIn_q", dataIn_q, expQ);
            check("cmp_nofi_dataIn", dataIn0,
                  model(a, b, cin, 1'b0, fault_site, fault_val));
            check("cmp_nofi_dataIn_q", dataIn_q0, expQ0);
        end
    end

    task automatic setIn(input logic [2:0] v);
        {a, b, cin} = v;
    endtask

    logic [1:0] sweepExp [8];

    initial begin
        sweepExp = '{2'b00, 2'b01, 2'b01, 2'b10,
                     2'b01, 2'b10, 2'b10, 2'b11};

        #2;
        check("reset_q", dataIn_q, 2'b00);
        check("reset_dataIn", dataIn, 2'b00);
        setIn(3'b110);
        #1;
        check("reset_comb_live", dataIn, 2'b10);
        check("reset_q_held", dataIn_q, 2'b00);
        @(posedge clk);
        #1;
        check("reset_q_after_edge", dataIn_q, 2'b00);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        started = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            setIn(3'(i));
            #2;
            check("sweep", dataIn, sweepExp[i]);
            check("sweep_nofi", dataIn0, sweepExp[i]);
        end

        @(posedge clk);
        #1;
        setIn(3'b110);
        #2;
        check("reg_before_edge", dataIn_q, 2'b11);
        @(posedge clk);
        #1;
        check("reg_after_edge", dataIn_q, 2'b10);

        setIn(3'b111);
        @(posedge clk);
        #1;
        check("areset_pre", dataIn_q, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_q_clear", dataIn_q, 2'b00);
        check("areset_comb", dataIn, 2'b11);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("areset_release_hold", dataIn_q, 2'b00);
        @(posedge clk);
        #1;
        check("areset_release_edge", dataIn_q, 2'b11);

        setIn(3'b100);
        fault_en = 1'b1;
        fault_site = 2'd0;
        fault_val = 1'b0;
        #1;
        check("fault_sum", dataIn, 2'b00);
        check("fault_sum_nofi", dataIn0, 2'b01);
        @(posedge clk);
        #1;
        check("fault_sum_q", dataIn_q, 2'b00);
        fault_en = 1'b0;
        #1;
        check("fault_sum_clear", dataIn, 2'b01);

        setIn(3'b001);
        fault_en = 1'b1;
        fault_site = 2'd2;
        fault_val = 1'b1;
        #1;
        check("fault_p", dataIn, 2'b10);
        check("fault_p_nofi", dataIn0, 2'b01);

        setIn(3'b111);
        fault_site = 2'd1;
        fault_val = 1'b0;
        #1;
        check("fault_cout", dataIn, 2'b01);

        setIn(3'b000);
        fault_site = 2'd3;
        fault_val = 1'b1;
        #1;
        check("fault_g", dataIn, 2'b10);

        setIn(3'b110);
        fault_site = 2'd2;
        fault_val = 1'b1;
        #1;
        check("fault_p_g_combo", dataIn, 2'b11);

        for (int s = 0; s < 4; s++) begin
            for (int v = 0; v < 2; v++) begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk);
                    #1;
                    fault_en = 1'b1;
                    fault_site = 2'(s);
                    fault_val = v[0];
                    setIn(3'(i));
                end
            end
        end

        @(posedge clk);
        #1;
        fault_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        started = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
